// File: rtl/ke_inv.sv
// AES-128 inverse key-schedule source: expands the cipher key forward to K10, then streams
// K10..K0 over a valid/ready port. Optional macro KE_INV_LASTKEY_EN adds key_last (key is K10).
module ke_inv (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
`ifdef KE_INV_LASTKEY_EN
    input  logic         key_last,
`endif
    output logic         busy,
    output logic [127:0] rk,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         done
);

    typedef enum logic [1:0] {StIdle, StFwd, StOut, StFin} state_e;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so byte b lives at bit offset (255 - b) * 8.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_e       state_q;
    logic [127:0] key_q;
    logic [3:0]   cnt_q;
    logic         valid_q, busy_q, done_q;

    logic [31:0]  c0, c1, c2, c3, c1i, c2i, c3i;
    logic [31:0]  sub_src, rot_w, sub_w, rcon_w, w4, w5, w6, w7, c0i;
    logic [127:0] fwd_key, inv_key;

    always_comb begin
        {c0, c1, c2, c3} = key_q;
        c3i = c3 ^ c2;
        c2i = c2 ^ c1;
        c1i = c1 ^ c0;
        // One SubWord path: forward uses w3, inverse uses the recovered c3'.
        sub_src = (state_q == StOut) ? c3i : c3;
        rot_w   = {sub_src[23:0], sub_src[31:24]};
        sub_w   = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
        rcon_w  = {rcon(cnt_q), 24'h0};
        w4      = c0 ^ sub_w ^ rcon_w;
        w5      = c1 ^ w4;
        w6      = c2 ^ w5;
        w7      = c3 ^ w6;
        c0i     = c0 ^ sub_w ^ rcon_w;
        fwd_key = {w4, w5, w6, w7};
        inv_key = {c0i, c1i, c2i, c3i};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            key_q   <= 128'h0;
            cnt_q   <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        key_q  <= key;
                        busy_q <= 1'b1;
`ifdef KE_INV_LASTKEY_EN
                        if (key_last) begin
                            state_q <= StOut;
                            cnt_q   <= 4'd10;
                            valid_q <= 1'b1;
                        end else
`endif
                        begin
                            state_q <= StFwd;
                            cnt_q   <= 4'd1;
                        end
                    end
                end
                StFwd: begin
                    key_q <= fwd_key;
                    if (cnt_q == 4'd10) begin
                        state_q <= StOut;
                        valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StOut: begin
                    if (rk_ready) begin
                        if (cnt_q == 4'd0) begin
                            state_q <= StFin;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            key_q <= inv_key;
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy     = busy_q;
    assign rk       = key_q;
    assign rk_idx   = cnt_q;
    assign rk_valid = valid_q;
    assign done     = done_q;

endmodule

// File: tb/tb_ke_inv.sv
// Directed self-checking bench for ke_inv: FIPS-197 A.1 schedule, stalls, ignored restarts,
// mid-schedule reset and the all-zero key.
module tb_ke_inv;

    logic         clk = 1'b0;
    logic         rst_n, start, rk_ready, busy, rk_valid, done;
    logic [127:0] key, rk;
    logic [3:0]   rk_idx;
`ifdef KE_INV_LASTKEY_EN
    logic         key_last = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [127:0] exp_k [0:10];

    always #5 clk = ~clk;

    ke_inv dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key      (key),
`ifdef KE_INV_LASTKEY_EN
        .key_last (key_last),
`endif
        .busy     (busy),
        .rk       (rk),
        .rk_idx   (rk_idx),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .done     (done)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Start a schedule at the current negedge and follow it through done.
    task automatic run_seq(input logic [127:0] k, input bit kl, input int lat, input bit full,
                           input bit rnd, input bit poke, input logic [127:0] e10,
                           input logic [127:0] e0);
        int n;
        int idx;
        bit fin;
        start = 1'b1;
        key   = k;
`ifdef KE_INV_LASTKEY_EN
        key_last = kl;
`endif
        n = 0;
        do begin
            @(negedge clk);
            n++;
            start = poke && (n == 3);
            key   = (poke && n == 3) ? ~k : k;
        end while (!rk_valid && n < 40);
        check("latency", 128'(n), 128'(lat));
        check("busy_run", 128'(busy), 128'd1);
        idx = 10;
        fin = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            check("valid", 128'(rk_valid), 128'd1);
            check("done_early", 128'(done), 128'd0);
            check("rk_idx", 128'(rk_idx), 128'(idx));
            if (full) check("rk", rk, exp_k[idx]);
            else if (idx == 10) check("rk10", rk, e10);
            else if (idx == 0) check("rk0", rk, e0);
            rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start    = poke && (c == 4);
            key      = ~k;
            if (rk_ready) begin
                if (idx == 0) fin = 1'b1;
                else idx--;
            end
            @(negedge clk);
        end
        if (!fin) check("timeout", 128'd0, 128'd1);
        rk_ready = 1'b0;
        start    = 1'b0;
        check("done_pulse", 128'(done), 128'd1);
        check("valid_fin", 128'(rk_valid), 128'd0);
        @(negedge clk);
        check("done_off", 128'(done), 128'd0);
        check("busy_off", 128'(busy), 128'd0);
`ifdef KE_INV_LASTKEY_EN
        key_last = 1'b0;
`endif
    endtask

    initial begin
        exp_k[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp_k[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_k[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_k[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_k[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_k[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_k[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_k[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_k[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_k[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_k[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; key = 128'h0;
        repeat (3) @(negedge clk);
        check("rst_rk", rk, 128'h0);
        check("rst_idx", 128'(rk_idx), 128'd0);
        check("rst_valid", 128'(rk_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_seq(exp_k[0], 1'b0, 11, 1'b1, 1'b0, 1'b0, 128'h0, 128'h0);
        run_seq(exp_k[0], 1'b0, 11, 1'b1, 1'b1, 1'b1, 128'h0, 128'h0);

        // Abort while K5 is held under backpressure.
        start = 1'b1; key = exp_k[0]; rk_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (rk_valid && rk_idx == 4'd5) break;
        end
        rk_ready = 1'b0;
        check("hold_idx5", 128'(rk_idx), 128'd5);
        check("hold_rk5", rk, exp_k[5]);
        @(negedge clk);
        check("stall_idx5", 128'(rk_idx), 128'd5);
        check("stall_rk5", rk, exp_k[5]);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_valid", 128'(rk_valid), 128'd0);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_rk", rk, 128'h0);
        check("abort_idx", 128'(rk_idx), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_done", 128'(done), 128'd0);
        run_seq(exp_k[0], 1'b0, 11, 1'b1, 1'b1, 1'b0, 128'h0, 128'h0);

        run_seq(128'h0, 1'b0, 11, 1'b0, 1'b0, 1'b0,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e, 128'h0);
`ifdef KE_INV_LASTKEY_EN
        run_seq(exp_k[10], 1'b1, 1, 1'b1, 1'b0, 1'b0, 128'h0, 128'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ke_inv.md
KE_INV -- requirements
Module: ke_inv

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request a new schedule; sampled only in IDLE.
REQ-005 key  input  128  AES-128 cipher key; key[127:96] = word w0 (FIPS-197 byte order); sampled with accepted start.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 rk  output  128  current round key; same word order as key.
REQ-008 rk_idx  output  4  round number of rk (10 down to 0).
REQ-009 rk_valid  output  1  rk/rk_idx valid.
REQ-010 rk_ready  input  1  consumer accepts rk; a transfer occurs when rk_valid and rk_ready are both high.
REQ-011 done  output  1  one-cycle pulse after the round-0 transfer.

Function
REQ-012 The block SHALL deliver the decryption-order round keys K10, K9, ..., K0 of the AES-128 key schedule, one per transfer.
REQ-013 FSM states SHALL be IDLE, FWD, OUT and FIN.
REQ-014 IDLE: start=1 SHALL load key into a 128-bit working register, set the round counter to 1 and go to FWD; start=0 SHALL keep IDLE.
REQ-015 FWD: each cycle SHALL replace the register with K(r) derived from K(r-1) using RotWord, SubWord (FIPS-197 forward S-box) and Rcon[r], then increment r.
REQ-016 After r=10 is computed, FWD SHALL go to OUT with register=K10 and rk_idx=10.
REQ-017 The first rk_valid SHALL occur exactly 11 cycles after the cycle in which start is accepted.
REQ-018 OUT: rk_valid=1; rk and rk_idx SHALL be held stable while rk_ready=0.
REQ-019 A transfer with rk_idx=i>0 SHALL load K(i-1) the next cycle via the inverse step: c3'=c3^c2, c2'=c2^c1, c1'=c1^c0, c0'=c0^SubWord(RotWord(c3'))^Rcon[i], and decrement rk_idx.
REQ-020 A transfer with rk_idx=0 SHALL go to FIN. rk_valid SHALL be 0 in FIN.
REQ-021 FIN SHALL assert done for exactly one cycle and return to IDLE.
REQ-022 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex), placed in the MSB byte of the word.
REQ-023 start SHALL be ignored while busy=1; no restart and no key re-sample.
REQ-024 Back-to-back transfers (rk_ready held high) SHALL deliver one key per cycle: 11 consecutive cycles from K10 to K0.
REQ-025 The inverse step SHALL use one 4-byte SubWord path shared with the forward step. The S-box SHALL be combinational.

Reset
REQ-026 While rst_n=0 at a clock edge, the FSM SHALL enter IDLE. Outputs after reset: rk=0, rk_idx=0, rk_valid=0, busy=0, done=0; the working register and counter SHALL be cleared.
REQ-027 Reset in any state, including mid-FWD and mid-OUT with rk_valid high, SHALL abort the schedule with no further transfers and no done pulse.

Configuration
REQ-028 Macro KE_INV_LASTKEY_EN: when defined, the block SHALL add input key_last (1 bit). An accepted start with key_last=1 SHALL treat key as K10 and go directly to OUT the next cycle, with the first rk_valid 1 cycle after start. key_last=0 SHALL behave as REQ-014.
REQ-029 Without KE_INV_LASTKEY_EN, the key_last port SHALL be absent and every start SHALL use the FWD phase.

Verification
REQ-030 Reset, then start with key=2b7e151628aed2a6abf7158809cf4f3c and rk_ready=1 -> rk_valid rises 11 cycles later with rk=d014f9a8c9ee2589e13f0cc8b6630ca6 and rk_idx=10. Next cycle rk=ac7766f319fadc2128d12941575c006e, rk_idx=9. The final key is rk=2b7e1516...4f3c with rk_idx=0, followed by a done pulse.
REQ-031 Same key, rk_ready toggled randomly -> rk/rk_idx stable while stalled, and the sequence is identical to REQ-030 (all 11 keys match FIPS-197 A.1).
REQ-032 start pulsed again during FWD and OUT -> ignored; the sequence is unchanged, with a single done pulse.
REQ-033 rst_n=0 while rk_idx=5 is held -> next cycle rk_valid=0, busy=0, rk=0. A new start then produces the full sequence from K10.
REQ-034 Key=000...0 -> K10=b4ef5bcb3e92e21123e951cf6f8f188e; K0=0 is delivered last.
REQ-035 With KE_INV_LASTKEY_EN: start with key_last=1 and key=d014f9a8c9ee2589e13f0cc8b6630ca6 -> rk_valid 1 cycle later, and the sequence ends with rk=2b7e151628aed2a6abf7158809cf4f3c.
